// File: rtl/npc_seq_unit.sv
// rtl/npc_seq_unit.sv - registered PC with next-PC selection, return-address stack, exception redirect and ERET
//
// Purpose: holds the architectural PC and picks the next one each cycle.
// Each posedge applies the first of: rst, exc_req, stall, eret, npcctr op.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   npcctr, br_cond                next-PC op select and branch condition
//   addr, offset, jr_addr          jump immediate, branch word offset, register target
//   stall, exc_req, eret           hold, exception entry, exception return
//   pc, npc, pc_plus4, epc         current PC, selected next PC, link value, saved PC
//   ras_empty, ras_full, ras_ovf   return-stack status (ras_ovf is sticky)
//   align_err                      misaligned JR / empty-stack RET target
module npc_seq_unit #(
    parameter int unsigned        WIDTH     = 32,
    parameter int unsigned        JADDR_W   = 26,
    parameter int unsigned        OFF_W     = 16,
    parameter logic [WIDTH-1:0]   RESET_VEC = 32'h0000_3000,
    parameter logic [WIDTH-1:0]   EXC_VEC   = 32'h0000_4180,
    parameter int unsigned        RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         npcctr,
    input  logic               br_cond,
    input  logic [JADDR_W-1:0] addr,
    input  logic [OFF_W-1:0]   offset,
    input  logic [WIDTH-1:0]   jr_addr,
    input  logic               stall,
    input  logic               exc_req,
    input  logic               eret,
    output logic [WIDTH-1:0]   pc,
    output logic [WIDTH-1:0]   npc,
    output logic [WIDTH-1:0]   pc_plus4,
    output logic [WIDTH-1:0]   epc,
    output logic               ras_empty,
    output logic               ras_full,
    output logic               ras_ovf,
    output logic               align_err
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);

    localparam logic [2:0] OP_SEQ = 3'b000;
    localparam logic [2:0] OP_BR  = 3'b001;
    localparam logic [2:0] OP_J   = 3'b010;
    localparam logic [2:0] OP_JR  = 3'b011;
    localparam logic [2:0] OP_JAL = 3'b100;
    localparam logic [2:0] OP_RET = 3'b101;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic             push, pop;
    logic [WIDTH-1:0] br_tgt, j_tgt, jr_tgt, ret_tgt, op_tgt;
    logic [WIDTH-1:0] off_ext;
    logic [PW-1:0]    top_idx;
    logic             empty_w, full_w;

    assign empty_w = (cnt_q == '0);
    assign full_w  = (cnt_q == (PW+1)'(RAS_DEPTH));

    // ptr_q is the next write slot, so the top of stack sits one below it.
    // When full, ptr_q also lands on the oldest entry, which makes an
    // overflowing push overwrite it in circular fashion.
    assign top_idx = ptr_q - 1'b1;

    assign pc_plus4 = pc_q + WIDTH'(4);
    assign off_ext  = {{(WIDTH-OFF_W){offset[OFF_W-1]}}, offset};
    assign br_tgt   = br_cond ? (pc_plus4 + (off_ext << 2)) : pc_plus4;
    assign j_tgt    = {pc_q[WIDTH-1:JADDR_W+2], addr, 2'b00};
    assign jr_tgt   = {jr_addr[WIDTH-1:2], 2'b00};
    assign ret_tgt  = empty_w ? jr_tgt : ras_q[top_idx];

    always_comb begin
        op_tgt = pc_plus4;
        unique case (npcctr)
            OP_BR:          op_tgt = br_tgt;
            OP_J, OP_JAL:   op_tgt = j_tgt;
            OP_JR:          op_tgt = jr_tgt;
            OP_RET:         op_tgt = ret_tgt;
            default:        op_tgt = pc_plus4;
        endcase
    end

    // Flags the raw register target; it is reported but still force-aligned.
    assign align_err = ((npcctr == OP_JR) || ((npcctr == OP_RET) && empty_w))
                       && (jr_addr[1:0] != 2'b00);

    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        npc   = op_tgt;
        push  = 1'b0;
        pop   = 1'b0;
        if (exc_req) begin
            npc   = EXC_VEC;
            pc_d  = EXC_VEC;
            epc_d = pc_q;
        end else if (stall) begin
            npc = pc_q;
        end else if (eret) begin
            npc  = epc_q;
            pc_d = epc_q;
        end else begin
            pc_d = op_tgt;
            push = (npcctr == OP_JAL);
            pop  = (npcctr == OP_RET) && !empty_w;
            if (push) begin
                ptr_d = ptr_q + 1'b1;
                if (full_w) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (pop) begin
                ptr_d = ptr_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            epc_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Stack storage needs no reset: entries are only read when count covers them.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            ras_q[ptr_q] <= pc_plus4;
        end
    end

    assign pc        = pc_q;
    assign epc       = epc_q;
    assign ras_empty = empty_w;
    assign ras_full  = full_w;
    assign ras_ovf   = ovf_q;

endmodule

// File: tb/tb_npc_seq_unit.sv
// tb/tb_npc_seq_unit.sv - scoreboard bench for npc_seq_unit with a queue-based reference model
module tb_npc_seq_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] RV = 32'h0000_3000;
    localparam logic [31:0] EV = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  npcctr = 3'd0;
    logic        br_cond = 1'b0;
    logic [25:0] addr = '0;
    logic [15:0] offset = '0;
    logic [31:0] jr_addr = '0;
    logic        stall = 1'b0, exc_req = 1'b0, eret = 1'b0;
    logic [31:0] pc, npc, pc_plus4, epc;
    logic        ras_empty, ras_full, ras_ovf, align_err;

    always #5 clk = ~clk;

    npc_seq_unit dut (
        .clk(clk), .rst(rst), .npcctr(npcctr), .br_cond(br_cond), .addr(addr),
        .offset(offset), .jr_addr(jr_addr), .stall(stall), .exc_req(exc_req),
        .eret(eret), .pc(pc), .npc(npc), .pc_plus4(pc_plus4), .epc(epc),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf),
        .align_err(align_err)
    );

    typedef struct {
        bit          chk_comb;
        logic [31:0] npc, p4;
        bit          align;
        logic [31:0] pc_n, epc_n;
        bit          empty_n, full_n, ovf_n;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    bit drv_done = 0;

    // Reference state
    logic [31:0] m_pc = RV, m_epc = 0;
    logic [31:0] m_ras[$];
    bit m_ovf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic step(input bit r, input logic [2:0] op, input bit c,
                        input logic [25:0] a, input logic [15:0] o, input logic [31:0] jr,
                        input bit st, input bit ex, input bit er);
        exp_t e;
        logic [31:0] tgt, p4, ext;
        @(negedge clk);
        rst = r; npcctr = op; br_cond = c; addr = a; offset = o; jr_addr = jr;
        stall = st; exc_req = ex; eret = er;
        p4  = m_pc + 32'd4;
        ext = 32'(signed'(o)) * 4;
        case (op)
            3'd1:       tgt = c ? p4 + ext : p4;
            3'd2, 3'd4: tgt = {m_pc[31:28], a, 2'b00};
            3'd3:       tgt = jr & ~32'd3;
            3'd5:       tgt = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : (jr & ~32'd3);
            default:    tgt = p4;
        endcase
        e.chk_comb = !r;
        e.p4 = p4;
        e.align = ((op == 3'd3) || (op == 3'd5 && m_ras.size() == 0)) && (jr[1:0] != 0);
        if (r) begin
            e.npc = 0;
            m_pc = RV; m_epc = 0; m_ras.delete(); m_ovf = 0;
        end else if (ex) begin
            e.npc = EV; m_epc = m_pc; m_pc = EV;
        end else if (st) begin
            e.npc = m_pc;
        end else if (er) begin
            e.npc = m_epc; m_pc = m_epc;
        end else begin
            e.npc = tgt;
            if (op == 3'd4) begin
                if (m_ras.size() == DEPTH) begin
                    m_ovf = 1;
                    void'(m_ras.pop_front());
                end
                m_ras.push_back(p4);
            end else if (op == 3'd5 && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
            m_pc = tgt;
        end
        e.pc_n = m_pc; e.epc_n = m_epc;
        e.empty_n = (m_ras.size() == 0);
        e.full_n = (m_ras.size() == DEPTH);
        e.ovf_n = m_ovf;
        sb.push_back(e);
    endtask

    task automatic op1(input logic [2:0] op, input logic [25:0] a, input logic [15:0] o,
                       input bit c, input logic [31:0] jr);
        step(0, op, c, a, o, jr, 0, 0, 0);
    endtask

    // Monitor: comb outputs just before the edge, registered outputs just after.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_comb) begin
                    chk("npc", npc, e.npc);
                    chk("pc_plus4", pc_plus4, e.p4);
                    chk("align_err", 32'(align_err), 32'(e.align));
                end
                @(posedge clk);
                #1;
                chk("pc", pc, e.pc_n);
                chk("epc", epc, e.epc_n);
                chk("ras_empty", 32'(ras_empty), 32'(e.empty_n));
                chk("ras_full", 32'(ras_full), 32'(e.full_n));
                chk("ras_ovf", 32'(ras_ovf), 32'(e.ovf_n));
            end
        end
    end

    initial begin
        int guard;
        // Reset then sequential flow
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) op1(3'd0, 0, 0, 0, 0);
        // Branch back / not taken from 0x3010
        op1(3'd2, 26'hC04, 0, 0, 0);
        op1(3'd1, 0, 16'hFFFC, 1, 0);
        op1(3'd2, 26'hC04, 0, 0, 0);
        op1(3'd1, 0, 16'hFFFC, 0, 0);
        // Call/return nesting
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        op1(3'd4, 26'h100, 0, 0, 0);
        op1(3'd4, 26'h040, 0, 0, 0);
        op1(3'd5, 0, 0, 0, 0);
        op1(3'd5, 0, 0, 0, 0);
        // Overflow and drain, then misaligned empty RET
        for (int i = 0; i < 5; i++) op1(3'd4, 26'(32'h200 + i * 32'h40), 0, 0, 0);
        for (int i = 0; i < 4; i++) op1(3'd5, 0, 0, 0, 0);
        op1(3'd5, 0, 0, 0, 32'h2002);
        // Exception over stall, stall hold, eret ignoring JAL
        op1(3'd2, 26'hC08, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 3'd4, 0, 26'h123, 0, 0, 0, 0, 1);
        // Mid-operation reset with JAL
        op1(3'd4, 26'h300, 0, 0, 0);
        op1(3'd4, 26'h310, 0, 0, 0);
        step(1, 3'd4, 0, 26'h320, 0, 0, 0, 0, 0);
        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(63) == 0, 3'($urandom_range(7)), 1'($urandom),
                 26'($urandom), 16'($urandom), $urandom,
                 $urandom_range(7) == 0, $urandom_range(15) == 0, $urandom_range(7) == 0);
        end
        drv_done = 1;
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        repeat (2) @(posedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
